updown_counter_mod: RTL
=======================

// Module: updown_counter_mod
// PURPOSE
//   Parametrised synchronous up/down modulo-N counter with synchronous parallel load,
//   count enable, cascade carry-in/carry-out and a registered wrap pulse.
//   Generalises the team's fixed 4-bit binary counter to any width and modulus.
//   Cascadable: co of stage k drives cin of stage k+1 for multi-digit BCD or timer chains.
// PARAMETERS
//   WIDTH    4   counter width in bits, 1..32
//   MODULUS  10  count range 0..MODULUS-1; legal range 2..2**WIDTH; elaboration fails if out of range
// PORTS
//   clk      in   1      rising-edge clock
//   mr       in   1      asynchronous active-low master reset
//   load     in   1      active-low synchronous parallel load
//   en       in   1      count enable, active-high
//   cin      in   1      cascade carry-in, active-high; tie 1 on the first stage
//   up_dn    in   1      1 = count up, 0 = count down
//   d        in   WIDTH  parallel load value
//   q        out  WIDTH  registered count value
//   co       out  1      combinational cascade carry/borrow out
//   wrap     out  1      registered one-cycle pulse, asserted the cycle after a wrap
//   ld_clip  out  1      registered one-cycle pulse, asserted the cycle after a clipped load
// BEHAVIOUR
//   - Reset: mr=0 forces q=0, wrap=0, ld_clip=0 immediately, independent of clk.
//     Release is synchronous to clk; the first action occurs on the first rising edge with mr=1.
//   - Priority per rising edge: mr > load (low) > step (en & cin) > hold.
//   - Load:
//     - load=0 gives q<=d, regardless of en, cin and up_dn.
//     - If d >= MODULUS, q<=MODULUS-1 and ld_clip<=1 for one cycle.
//     - wrap<=0 on any load.
//   - Step, up_dn=1:
//     - q<=q+1.
//     - If q==MODULUS-1, q<=0 and wrap<=1 for one cycle.
//   - Step, up_dn=0:
//     - q<=q-1.
//     - If q==0, q<=MODULUS-1 and wrap<=1 for one cycle.
//   - Hold: en=0 or cin=0 keeps q unchanged; wrap<=0 and ld_clip<=0.
//   - Terminal count:
//     - tc = (up_dn ? q==MODULUS-1 : q==0).
//     - co = en & cin & tc & load, so co is suppressed while a load is pending.
//     - co is purely combinational from the current inputs and q; zero latency for cascade ripple.
//   - up_dn may change on any cycle. The new direction applies on the same edge, and co follows it
//     combinationally.
//   - Arithmetic: internal step is computed in WIDTH+1 bits, so MODULUS==2**WIDTH wraps without overflow.
//   - Illegal q (>= MODULUS) cannot be produced by load or step; only reset or load changes q from
//     outside the count sequence.
//   - mr asserted mid-count: q=0 immediately, and pending wrap/ld_clip pulses are cancelled.
//   - Latency: load and step take 1 clk to appear on q; wrap and ld_clip appear 1 clk after the
//     causing edge's inputs were sampled.
// CONFIGURATION
//   - Macro UPDOWN_COUNTER_MOD_SATURATE_EN.
//   - Defined: saturating mode.
//     - At tc, a step holds q (MODULUS-1 going up, 0 going down). No wrap occurs and wrap stays 0.
//     - co still asserts per the formula above and acts as a "saturated" indicator.
//     - Loads and clipping are unchanged.
//   - Undefined (default): modulo wrap behaviour as above.
// TESTING
//   1. mr=0 pulse mid-count at q=7, asynchronous, between edges -> q=0 before the next edge;
//      wrap=0, ld_clip=0.
//   2. WIDTH=4, MODULUS=10, up, en=cin=1, 12 edges from q=0 -> q sequence 1..9,0,1,2;
//      co=1 only while q=9; wrap=1 in the cycle after q 9->0.
//   3. Down count from q=1 -> 0 then 9; co=1 while q=0 and up_dn=0; wrap pulses once.
//   4. load=0 with d=4'd13 -> q=9, ld_clip=1 for one cycle.
//      load=0 with d=3 while en=1 -> q=3, co=0 during the load cycle.
//   5. Two stages cascaded (co0->cin1), MODULUS=10 -> 100 enabled edges from 00 return to 00;
//      stage1 steps exactly on stage0 9->0; en=0 or cin0=0 freezes both stages.
//   6. With UPDOWN_COUNTER_MOD_SATURATE_EN, MODULUS=10, up from q=8 for 3 edges -> q=9,9,9;
//      wrap stays 0, co=1 at q=9.
//      Down from q=1 for 2 edges -> q=0,0.

Source files
------------

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down modulo-MODULUS counter with
// active-low synchronous parallel load, count enable, cascade carry-in and
// carry-out, and registered wrap / clipped-load pulses.
//
// Build option: define UPDOWN_COUNTER_MOD_SATURATE_EN to make a step at
// terminal count hold the value instead of wrapping. In that mode wrap never
// asserts, and co acts as a "saturated" flag.
//
// All next-state arithmetic is done in WIDTH+1 bits. This lets
// MODULUS == 2**WIDTH be handled without overflow.
module updown_counter_mod #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             load,
    input  logic             en,
    input  logic             cin,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             wrap,
    output logic             ld_clip
);

    // Refuse to elaborate with an unusable width or modulus.
    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be in 1..32");
    end
    if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
        $error("updown_counter_mod: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_W = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   MAX_W = MOD_W - ONE_W;
    localparam logic [WIDTH-1:0] MAX_Q = MAX_W[WIDTH-1:0];

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             ld_clip_reg;
    logic             ld_clip_next;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic             step;
    logic             tc;
    logic             unused_carry_bits;

    assign q_ext   = {1'b0, q_reg};
    assign d_ext   = {1'b0, d};
    assign inc_ext = q_ext + ONE_W;
    assign dec_ext = q_ext - ONE_W;

    // The top bits are only ever set at terminal count, and terminal count
    // takes a different path in the next-state logic, so they are never used.
    assign unused_carry_bits = inc_ext[WIDTH] ^ dec_ext[WIDTH];

    assign step = en & cin;

    // Terminal count follows the current direction, with zero latency.
    assign tc = up_dn ? (q_ext == MAX_W) : (q_reg == {WIDTH{1'b0}});

    // co is combinational so that a cascade ripples within the same cycle.
    // A pending load (load low) suppresses it.
    assign co = step & tc & load;

    // Next-state selection. Load has priority over step, and step has
    // priority over hold.
    always_comb begin
        q_next       = q_reg;
        wrap_next    = 1'b0;
        ld_clip_next = 1'b0;
        if (!load) begin
            if (d_ext >= MOD_W) begin
                q_next       = MAX_Q;
                ld_clip_next = 1'b1;
            end else begin
                q_next = d;
            end
        end else if (step) begin
            if (tc) begin
`ifdef UPDOWN_COUNTER_MOD_SATURATE_EN
                q_next = q_reg;
`else
                q_next    = up_dn ? {WIDTH{1'b0}} : MAX_Q;
                wrap_next = 1'b1;
`endif
            end else if (up_dn) begin
                q_next = inc_ext[WIDTH-1:0];
            end else begin
                q_next = dec_ext[WIDTH-1:0];
            end
        end
    end

    // State register. mr clears the count immediately and cancels any
    // pulse that is still pending.
    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            q_reg       <= {WIDTH{1'b0}};
            wrap_reg    <= 1'b0;
            ld_clip_reg <= 1'b0;
        end else begin
            q_reg       <= q_next;
            wrap_reg    <= wrap_next;
            ld_clip_reg <= ld_clip_next;
        end
    end

    assign q       = q_reg;
    assign wrap    = wrap_reg;
    assign ld_clip = ld_clip_reg;

endmodule
